seven_seg_scanner: RTL and testbench

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

---
 rtl/seven_seg_scanner.sv | 132 +++++++++++++
 tb/tb_seven_seg_scanner.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// Eight-digit multiplexed seven-segment scanner with dead-time blanking, frame-latched inputs
// and leading-zero suppression; all outputs registered one cycle behind the scan state.
module seven_seg_scanner #(
    parameter int REFRESH_CYCLES = 50000,
    parameter int DEADTIME       = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] hex_in,
    input  logic [7:0]  dp_in,
    input  logic        blank_lz,
    input  logic        enable,
    output logic [7:0]  anode,
    output logic [6:0]  cathode,
    output logic        dp,
    output logic        frame_done
);

    localparam int PW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [PW-1:0] LAST_CNT = PW'(REFRESH_CYCLES - 1);
    localparam logic [PW-1:0] DEAD_CNT = PW'(DEADTIME);

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t          state, state_next;
    logic [PW-1:0]   cnt, cnt_next;
    logic [2:0]      idx, idx_next;
    logic            slot_wrap, frame_wrap;
    logic            load_pending;
    logic [31:0]     shadow_hex;
    logic [7:0]      shadow_dp;
    logic [7:0]      lz_blank;
    logic [3:0]      nibble;
    logic [7:0]      anode_next;
    logic [6:0]      cathode_next;
    logic            dp_next;

    function automatic logic [6:0] seg_encode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        slot_wrap  = (cnt == LAST_CNT);
        frame_wrap = slot_wrap && (idx == 3'd7);
        cnt_next   = slot_wrap ? '0 : cnt + PW'(1);
        idx_next   = slot_wrap ? idx + 3'd1 : idx;
        state_next = (cnt_next < DEAD_CNT) ? BLANK : DRIVE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            idx   <= 3'd0;
            state <= BLANK;
        end else begin
            cnt   <= cnt_next;
            idx   <= idx_next;
            state <= state_next;
        end
    end

    // Inputs are latched once per frame so a frame never shows a mix of old and new digits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_hex   <= 32'h0;
            shadow_dp    <= 8'h0;
            load_pending <= 1'b1;
        end else begin
            load_pending <= 1'b0;
            if (load_pending || frame_wrap) begin
                shadow_hex <= hex_in;
                shadow_dp  <= dp_in;
            end
        end
    end

    always_comb begin : lz_scan
        logic all_zero;
        all_zero = 1'b1;
        lz_blank = 8'h00;
        for (int k = 7; k >= 1; k--) begin
            all_zero    = all_zero && (shadow_hex[4*k +: 4] == 4'h0);
            lz_blank[k] = blank_lz && all_zero;
        end
    end

    always_comb begin
        nibble       = shadow_hex[{idx, 2'b00} +: 4];
        anode_next   = 8'hFF;
        cathode_next = 7'h7F;
        dp_next      = 1'b1;
        if (state == DRIVE && enable && !lz_blank[idx]) begin
            anode_next[idx] = 1'b0;
            cathode_next    = seg_encode(nibble);
            dp_next         = ~shadow_dp[idx];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            anode      <= 8'hFF;
            cathode    <= 7'h7F;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            anode      <= anode_next;
            cathode    <= cathode_next;
            dp         <= dp_next;
            frame_done <= frame_wrap;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner with an 8-cycle slot and 2 dead-time cycles.
module tb_seven_seg_scanner;

    logic        clk;
    logic        reset;
    logic [31:0] hex_in;
    logic [7:0]  dp_in;
    logic        blank_lz;
    logic        enable;
    logic [7:0]  anode;
    logic [6:0]  cathode;
    logic        dp;
    logic        frame_done;

    seven_seg_scanner #(.REFRESH_CYCLES(8), .DEADTIME(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .hex_in     (hex_in),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .enable     (enable),
        .anode      (anode),
        .cathode    (cathode),
        .dp         (dp),
        .frame_done (frame_done)
    );

    typedef struct {
        int         cyc;
        int         j;
        logic [7:0] an;
        logic [6:0] ca;
        logic       dpv;
        logic       fd;
        bit         seg;
    } exp_t;

    exp_t sb[$];
    int   edge_cnt = 0;
    int   base     = 0;
    int   n_total  = 0;
    int   n_pass   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // j counts clock edges since the latest reset release; edge 1 is the first one.
    task automatic push(input int j, input logic [7:0] an, input logic [6:0] ca,
                        input logic dpv, input logic fd, input bit seg);
        exp_t e;
        e.cyc = base + j; e.j = j; e.an = an; e.ca = ca; e.dpv = dpv; e.fd = fd; e.seg = seg;
        sb.push_back(e);
    endtask

    task automatic goto_j(input int j);
        while (edge_cnt - base < j) @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        int   jj;
        forever begin
            @(negedge clk);
            #1;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc <= edge_cnt) begin
                    e = sb[i];
                    sb.delete(i);
                    if (e.cyc < edge_cnt) check($sformatf("late_entry j%0d", e.j), edge_cnt, e.cyc);
                    if (e.seg) begin
                        check($sformatf("anode j%0d", e.j), anode, e.an);
                        check($sformatf("cathode j%0d", e.j), cathode, e.ca);
                        check($sformatf("dp j%0d", e.j), dp, e.dpv);
                    end
                    check($sformatf("frame_done j%0d", e.j), frame_done, e.fd);
                end
            end
            if (!reset) begin
                jj = edge_cnt - base;
                check($sformatf("onehot j%0d", jj), ($countones(~anode) <= 1), 1);
                if (jj >= 1 && ((jj - 1) % 8) < 2)
                    check($sformatf("blank_phase j%0d", jj), anode, 8'hFF);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; hex_in = 32'h0; dp_in = 8'h0; blank_lz = 1'b0; enable = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_anode", anode, 8'hFF);
        check("reset_cathode", cathode, 7'h7F);
        check("reset_dp", dp, 1'b1);
        check("reset_frame_done", frame_done, 1'b0);

        // Basic scan of 12345678
        hex_in = 32'h12345678; enable = 1'b1;
        reset = 1'b0; base = edge_cnt;
        push(1, 8'hFF, 7'h7F, 1, 0, 1);
        push(2, 8'hFF, 7'h7F, 1, 0, 1);
        for (int j = 3; j <= 8; j++) push(j, 8'hFE, 7'h00, 1, 0, 1);
        push(9, 8'hFF, 7'h7F, 1, 0, 1);
        push(11, 8'hFD, 7'h78, 1, 0, 1);
        for (int j = 59; j <= 64; j++) push(j, 8'h7F, 7'h79, 1, (j == 64), 1);
        push(65, 8'hFF, 7'h7F, 1, 0, 1);

        // Mid-frame change must wait for the next frame
        goto_j(90);
        hex_in = 32'hFFFFFFFF;
        push(93, 8'hF7, 7'h12, 1, 0, 1);
        push(99, 8'hEF, 7'h19, 1, 0, 1);
        push(123, 8'h7F, 7'h79, 1, 0, 1);
        push(128, 8'h7F, 7'h79, 1, 1, 1);
        push(131, 8'hFE, 7'h0E, 1, 0, 1);
        push(187, 8'h7F, 7'h0E, 1, 0, 1);
        push(192, 8'h7F, 7'h0E, 1, 1, 1);

        // Decimal point on digit 0, then enable drop mid-slot
        goto_j(150);
        dp_in = 8'h01;
        for (int j = 195; j <= 200; j++) push(j, 8'hFE, 7'h0E, 0, 0, 1);
        push(201, 8'hFF, 7'h7F, 1, 0, 1);
        push(203, 8'hFD, 7'h0E, 1, 0, 1);
        push(212, 8'hFB, 7'h0E, 1, 0, 1);
        push(213, 8'hFF, 7'h7F, 1, 0, 1);
        push(256, 8'hFF, 7'h7F, 1, 1, 0);
        push(259, 8'hFF, 7'h7F, 1, 0, 1);
        push(320, 8'hFF, 7'h7F, 1, 1, 0);
        goto_j(212);
        enable = 1'b0;

        // Leading-zero blanking; dp request on a blanked digit is dropped
        goto_j(270);
        enable = 1'b1; blank_lz = 1'b1; hex_in = 32'h000000A0; dp_in = 8'h04;
        push(323, 8'hFE, 7'h40, 1, 0, 1);
        push(331, 8'hFD, 7'h08, 1, 0, 1);
        push(339, 8'hFF, 7'h7F, 1, 0, 1);
        push(379, 8'hFF, 7'h7F, 1, 0, 1);
        push(384, 8'hFF, 7'h7F, 1, 1, 0);
        goto_j(350);
        hex_in = 32'h0;
        push(387, 8'hFE, 7'h40, 1, 0, 1);
        push(395, 8'hFF, 7'h7F, 1, 0, 1);
        goto_j(410);
        blank_lz = 1'b0;
        push(428, 8'hDF, 7'h40, 1, 0, 1);

        // Asynchronous reset between edges in slot 5 drive
        goto_j(428);
        #3 reset = 1'b1;
        #1;
        check("async_anode", anode, 8'hFF);
        check("async_cathode", cathode, 7'h7F);
        check("async_dp", dp, 1'b1);
        repeat (3) @(negedge clk);
        check("held_reset_anode", anode, 8'hFF);
        hex_in = 32'h12345678; dp_in = 8'h0; enable = 1'b1; blank_lz = 1'b0;
        reset = 1'b0; base = edge_cnt;
        push(1, 8'hFF, 7'h7F, 1, 0, 1);
        push(2, 8'hFF, 7'h7F, 1, 0, 1);
        push(3, 8'hFE, 7'h00, 1, 0, 1);
        push(64, 8'h7F, 7'h79, 1, 1, 1);
        for (int k = 2; k <= 10; k++) push(64 * k, 8'hFF, 7'h7F, 1, 1, 0);

        // Random inputs for ten frames; monitor checks one-hot and dead time each cycle
        goto_j(65);
        for (int i = 0; i < 640; i++) begin
            @(negedge clk);
            hex_in   = $urandom;
            dp_in    = 8'($urandom);
            enable   = 1'($urandom_range(0, 1));
            blank_lz = 1'($urandom_range(0, 1));
        end
        repeat (3) @(negedge clk);
        #2;
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
